// File: rtl/uart2wifi_core_uartx.sv
// UART core: baud tick generator, TX/RX FIFOs (first-word-fall-through) and TX/RX framers.
// Optional parity (parity_odd input, parity_err flag, PARITY states) under `UART2WIFI_UARTX_PARITY_EN.
module uart2wifi_core_uartx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_wr,
    input  logic [DATA_BITS-1:0] write_data,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    input  logic                 rx_rd,
    output logic [DATA_BITS-1:0] read_data,
    output logic                 rx_empty,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr
`ifdef UART2WIFI_UARTX_PARITY_EN
    ,
    input  logic                 parity_odd,
    output logic                 parity_err
`endif
);

    localparam int DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_HALF  = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART2WIFI_UARTX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------- oversample tick ----------------
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0]          tx_wp, tx_rp;
    logic                 tx_empty, tx_pop, tx_push;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_push  = tx_wr && (!tx_full || tx_pop);
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= write_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        end
    end

    // ---------------- TX framer ----------------
    state_t               tx_state, tx_state_n;
    logic [OW-1:0]        tx_os, tx_os_n;
    logic [3:0]           tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic                 tx_q, tx_n, tx_end;
`ifdef UART2WIFI_UARTX_PARITY_EN
    logic                 tx_par, tx_par_n;
`endif

    assign tx_end  = tick && (tx_os == OS_LAST);
    assign tx      = tx_q;
    assign tx_busy = (tx_state != S_IDLE) || !tx_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_os    <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_q     <= 1'b1;
`ifdef UART2WIFI_UARTX_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_os    <= tx_os_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_q     <= tx_n;
`ifdef UART2WIFI_UARTX_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_os_n    = tx_os;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_pop     = 1'b0;
        tx_n       = 1'b1;
`ifdef UART2WIFI_UARTX_PARITY_EN
        tx_par_n   = tx_par;
`endif
        if (tx_state != S_IDLE && tick) tx_os_n = (tx_os == OS_LAST) ? '0 : tx_os + 1'b1;
        case (tx_state)
            S_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_state_n = S_START;
                tx_os_n    = '0;
            end
            S_START: if (tx_end) begin
                tx_state_n = S_DATA;
                tx_bit_n   = '0;
            end
            S_DATA: if (tx_end) begin
                tx_sh_n = tx_sh >> 1;
                if (tx_bit == BIT_LAST) begin
`ifdef UART2WIFI_UARTX_PARITY_EN
                    tx_state_n = S_PARITY;
`else
                    tx_state_n = S_STOP;
`endif
                end else begin
                    tx_bit_n = tx_bit + 1'b1;
                end
            end
`ifdef UART2WIFI_UARTX_PARITY_EN
            S_PARITY: if (tx_end) tx_state_n = S_STOP;
`endif
            // Chain straight into the next start bit when more data is queued.
            S_STOP: if (tx_end) begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = S_START;
                end else begin
                    tx_state_n = S_IDLE;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
        if (tx_pop) begin
            tx_sh_n = tx_head;
`ifdef UART2WIFI_UARTX_PARITY_EN
            tx_par_n = ^tx_head ^ parity_odd;
`endif
        end
        case (tx_state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = tx_sh_n[0];
`ifdef UART2WIFI_UARTX_PARITY_EN
            S_PARITY: tx_n = tx_par_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]          rx_wp, rx_rp;
    logic                 rx_full, rx_pop, rx_push, rx_push_ok;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;

    assign rx_empty   = (rx_wp == rx_rp);
    assign rx_full    = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_pop     = rx_rd && !rx_empty;
    assign rx_push_ok = rx_push && (!rx_full || rx_pop);
    assign read_data  = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)     rx_rp <= rx_rp + 1'b1;
        end
    end

    // ---------------- RX framer ----------------
    logic          rx_s1, rx_s2, rx_prev;
    state_t        rx_state, rx_state_n;
    logic [OW-1:0] rx_os, rx_os_n;
    logic [3:0]    rx_bit, rx_bit_n;
    logic          rx_end, rx_half, fe_set, ov_set;
`ifdef UART2WIFI_UARTX_PARITY_EN
    logic          pe_set;
`endif

    assign rx_end  = tick && (rx_os == OS_LAST);
    assign rx_half = tick && (rx_os == OS_HALF);
    assign ov_set  = rx_push && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= S_IDLE;
            rx_os     <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART2WIFI_UARTX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            rx_state  <= rx_state_n;
            rx_os     <= rx_os_n;
            rx_bit    <= rx_bit_n;
            rx_sh     <= rx_sh_n;
            // A new error in the same cycle as err_clr wins.
            frame_err <= fe_set | (frame_err & ~err_clr);
            overrun   <= ov_set | (overrun & ~err_clr);
`ifdef UART2WIFI_UARTX_PARITY_EN
            parity_err <= pe_set | (parity_err & ~err_clr);
`endif
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_os_n    = rx_os;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
`ifdef UART2WIFI_UARTX_PARITY_EN
        pe_set     = 1'b0;
`endif
        if (rx_state != S_IDLE && tick) rx_os_n = (rx_os == OS_LAST) ? '0 : rx_os + 1'b1;
        case (rx_state)
            S_IDLE: begin
                rx_os_n = '0;
                if (rx_prev && !rx_s2) rx_state_n = S_START;
            end
            // Mid start bit: a line already back high was only a glitch.
            S_START: if (rx_half) begin
                rx_os_n    = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_end) begin
                rx_sh_n = {rx_s2, rx_sh[DATA_BITS-1:1]};
                if (rx_bit == BIT_LAST) begin
`ifdef UART2WIFI_UARTX_PARITY_EN
                    rx_state_n = S_PARITY;
`else
                    rx_state_n = S_STOP;
`endif
                end else begin
                    rx_bit_n = rx_bit + 1'b1;
                end
            end
`ifdef UART2WIFI_UARTX_PARITY_EN
            S_PARITY: if (rx_end) begin
                pe_set     = ^rx_sh ^ rx_s2 ^ parity_odd;
                rx_state_n = S_STOP;
            end
`endif
            S_STOP: if (rx_end) begin
                rx_push    = 1'b1;
                fe_set     = !rx_s2;
                rx_state_n = S_IDLE;
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart2wifi_core_uartx.sv
// Directed bench for uart2wifi_core_uartx, scaled clock/baud so one bit is 48 clocks.
// A background monitor decodes the tx line into a queue of {stop, data} words.
module tb_uart2wifi_core_uartx;

    localparam int CLK_HZ = 48000000;
    localparam int BAUD   = 1000000;
    localparam int OS     = 16;
    localparam int DB     = 8;
    localparam int DEPTH  = 16;
    localparam int DIV    = 3;
    localparam int BIT    = DIV * OS;
`ifdef UART2WIFI_UARTX_PARITY_EN
    localparam int NPB    = 1;
`else
    localparam int NPB    = 0;
`endif
    localparam int FRAME  = (DB + 2 + NPB) * BIT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_wr = 1'b0;
    logic [DB-1:0] write_data = '0;
    logic          tx_full, tx_busy, tx;
    logic          rx = 1'b1;
    logic          rx_rd = 1'b0;
    logic [DB-1:0] read_data;
    logic          rx_empty, frame_err, overrun;
    logic          err_clr = 1'b0;
`ifdef UART2WIFI_UARTX_PARITY_EN
    logic          parity_odd = 1'b0;
    logic          parity_err;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic       mon_en = 1'b0;
    logic [8:0] mon_q[$];
    int         mon_t[$];

    uart2wifi_core_uartx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .tx_wr(tx_wr), .write_data(write_data),
        .tx_full(tx_full), .tx_busy(tx_busy), .tx(tx),
        .rx(rx), .rx_rd(rx_rd), .read_data(read_data), .rx_empty(rx_empty),
        .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
`ifdef UART2WIFI_UARTX_PARITY_EN
        , .parity_odd(parity_odd), .parity_err(parity_err)
`endif
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : tx_monitor
        logic [8:0] w;
        int t0;
        wait (mon_en);
        forever begin
            @(negedge tx);
            t0 = cyc;
            w  = '0;
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < DB + NPB + 1; i++) begin
                repeat (BIT) @(negedge clk);
                if (i < DB) w[i] = tx;
                if (i == DB + NPB) w[8] = tx;
            end
            mon_q.push_back(w);
            mon_t.push_back(t0);
        end
    end

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_b);
`ifdef UART2WIFI_UARTX_PARITY_EN
        send_bits({1'b1, stop_b, ^d ^ parity_odd, d, 1'b0}, 11);
`else
        send_bits({2'b11, stop_b, d, 1'b0}, 10);
`endif
    endtask

    task automatic pop_rx();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1)       begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (tx_full !== 1'b0)  begin failures++; $display("FAIL reset_tx_full got=%b exp=0", tx_full); end
        checks++; if (tx_busy !== 1'b0)  begin failures++; $display("FAIL reset_tx_busy got=%b exp=0", tx_busy); end
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL reset_rx_empty got=%b exp=1", rx_empty); end
        checks++; if (read_data !== 8'h00) begin failures++; $display("FAIL reset_read_data got=%h exp=00", read_data); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL reset_err_flags got=%b%b exp=00", frame_err, overrun);
        end
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_rx_basic();
        pop_rx();
        send_rx(8'h77, 1'b1);
        checks++; if (rx_empty !== 1'b0)   begin failures++; $display("FAIL rx1_empty got=%b exp=0", rx_empty); end
        checks++; if (read_data !== 8'h77) begin failures++; $display("FAIL rx1_data got=%h exp=77", read_data); end
        pop_rx();
        checks++; if (rx_empty !== 1'b1)   begin failures++; $display("FAIL rx1_pop_empty got=%b exp=1", rx_empty); end
        send_rx(8'h77, 1'b1);
        checks++; if (rx_empty !== 1'b0)   begin failures++; $display("FAIL rx2_empty got=%b exp=0", rx_empty); end
        checks++; if (read_data !== 8'h77) begin failures++; $display("FAIL rx2_data got=%h exp=77", read_data); end
        pop_rx();
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL rx_no_err got=%b%b exp=00", frame_err, overrun);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        mon_q.delete(); mon_t.delete();
        tx_wr = 1'b1; write_data = 8'h86;
        @(negedge clk);
        write_data = 8'hFA;
        @(negedge clk);
        tx_wr = 1'b0;
        for (int i = 0; i < 3 * FRAME && mon_q.size() < 2; i++) @(negedge clk);
        checks++;
        if (mon_q.size() < 2) begin
            failures++; $display("FAIL b2b_timeout got=%0d frames exp=2", mon_q.size());
        end else begin
            checks++; if (mon_q[0] !== 9'h186) begin failures++; $display("FAIL b2b_frame0 got=%h exp=186", mon_q[0]); end
            checks++; if (mon_q[1] !== 9'h1FA) begin failures++; $display("FAIL b2b_frame1 got=%h exp=1fa", mon_q[1]); end
            gap = mon_t[1] - mon_t[0];
            checks++; if (gap < FRAME - DIV - 1 || gap > FRAME + 1) begin
                failures++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, FRAME);
            end
            checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_stop got=%b exp=1", tx_busy); end
            repeat (BIT) @(negedge clk);
            checks++; if (tx_busy !== 1'b0 || tx !== 1'b1) begin
                failures++; $display("FAIL b2b_idle got busy=%b tx=%b exp busy=0 tx=1", tx_busy, tx);
            end
        end
    endtask

    task automatic test_tx_full();
        logic [8:0] exp;
        mon_q.delete(); mon_t.delete();
        for (int i = 0; i < 17; i++) begin
            tx_wr = 1'b1; write_data = 8'(8'h30 + i);
            @(negedge clk);
        end
        checks++; if (tx_full !== 1'b1) begin failures++; $display("FAIL txfull_set got=%b exp=1", tx_full); end
        write_data = 8'hEE;
        @(negedge clk);
        tx_wr = 1'b0;
        checks++; if (tx_full !== 1'b1) begin failures++; $display("FAIL txfull_drop got=%b exp=1", tx_full); end
        for (int i = 0; i < 20 * FRAME && mon_q.size() < 17; i++) @(negedge clk);
        repeat (2 * FRAME) @(negedge clk);
        checks++;
        if (mon_q.size() != 17) begin
            failures++; $display("FAIL txfull_count got=%0d exp=17", mon_q.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                exp = {1'b1, 8'(8'h30 + i)};
                checks++; if (mon_q[i] !== exp) begin
                    failures++; $display("FAIL txfull_word%0d got=%h exp=%h", i, mon_q[i], exp);
                end
            end
        end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL txfull_busy got=%b exp=0", tx_busy); end
    endtask

    task automatic test_frame_err();
        send_rx(8'h55, 1'b0);
        checks++; if (frame_err !== 1'b1)  begin failures++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
        checks++; if (read_data !== 8'h55) begin failures++; $display("FAIL ferr_data got=%h exp=55", read_data); end
        pop_rx();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (frame_err !== 1'b0)  begin failures++; $display("FAIL ferr_clr got=%b exp=0", frame_err); end
        checks++; if (rx_empty !== 1'b1)   begin failures++; $display("FAIL ferr_empty got=%b exp=1", rx_empty); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        for (int i = 0; i < 17; i++) send_rx(8'(8'h10 + i), 1'b1);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        for (int i = 0; i < 16; i++) begin
            exp = 8'(8'h10 + i);
            checks++; if (rx_empty !== 1'b0 || read_data !== exp) begin
                failures++; $display("FAIL ovr_pop%0d got=%h empty=%b exp=%h", i, read_data, rx_empty, exp);
            end
            pop_rx();
        end
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL ovr_drained got=%b exp=1", rx_empty); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (18) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL glitch_noword got=%b exp=1", rx_empty); end
        send_rx(8'hA3, 1'b1);
        checks++; if (read_data !== 8'hA3 || rx_empty !== 1'b0) begin
            failures++; $display("FAIL glitch_recover got=%h empty=%b exp=a3", read_data, rx_empty);
        end
        pop_rx();
    endtask

    task automatic test_rst_midframe();
        tx_wr = 1'b1; write_data = 8'h00; rx = 1'b0;
        @(negedge clk);
        tx_wr = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        checks++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin
            failures++; $display("FAIL rstmid_active got tx=%b busy=%b exp tx=0 busy=1", tx, tx_busy);
        end
        rst = 1'b1; rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_abort got tx=%b busy=%b exp tx=1 busy=0", tx, tx_busy);
        end
        repeat (12 * BIT) @(negedge clk);
        checks++; if (rx_empty !== 1'b1 || tx !== 1'b1) begin
            failures++; $display("FAIL rstmid_quiet got empty=%b tx=%b exp 1 1", rx_empty, tx);
        end
        mon_q.delete(); mon_t.delete();
    endtask

`ifdef UART2WIFI_UARTX_PARITY_EN
    task automatic test_parity();
        parity_odd = 1'b0;
        send_bits({1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_bad got=%b exp=1", parity_err); end
        pop_rx();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        send_bits({1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_good got=%b exp=0", parity_err); end
        checks++; if (read_data !== 8'h07) begin failures++; $display("FAIL par_data got=%h exp=07", read_data); end
        pop_rx();
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_rx_basic();
        test_back_to_back();
        test_tx_full();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_rst_midframe();
`ifdef UART2WIFI_UARTX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart2wifi_core_uartx.md
UART2WIFI_CORE_UARTX -- requirements
Module: uart2wifi_core_uartx

Interface
REQ-001 CLK_HZ, 50000000, input clock frequency in Hz.
REQ-002 BAUD, 19200, line bit rate.
REQ-003 OVERSAMPLE, 16, RX samples per bit; legal values 8 or 16.
REQ-004 DATA_BITS, 8, data bits per frame; legal range 5..8.
REQ-005 FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, 2..256.
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 tx_wr  in  1  push write_data into TX FIFO when high at clk edge.
REQ-009 write_data  in  DATA_BITS  TX byte; unused upper bits of 8 ignored.
REQ-010 tx_full  out  1  TX FIFO full.
REQ-011 tx_busy  out  1  TX shifter active or TX FIFO non-empty.
REQ-012 tx  out  1  serial output, idle high.
REQ-013 rx  in  1  asynchronous serial input, idle high.
REQ-014 rx_rd  in  1  pop RX FIFO when high at clk edge.
REQ-015 read_data  out  DATA_BITS  RX FIFO head (first-word-fall-through).
REQ-016 rx_empty  out  1  RX FIFO empty.
REQ-017 frame_err  out  1  sticky; stop bit sampled low.
REQ-018 overrun  out  1  sticky; frame completed while RX FIFO full.
REQ-019 err_clr  in  1  clears all sticky error flags on next edge.

Function
REQ-020 Tick generator SHALL pulse one clk every round(CLK_HZ/(BAUD*OVERSAMPLE)) cycles (163 at defaults); free-running counter from reset.
REQ-021 Frame: 1 start (0), DATA_BITS LSB-first, optional parity, 1 stop (1).
REQ-022 TX FSM states IDLE, START, DATA, PARITY, STOP; each state held OVERSAMPLE ticks; IDLE->START when FIFO non-empty, popping head same cycle.
REQ-023 After STOP, next queued word SHALL start with no idle gap (back-to-back frames).
REQ-024 tx_wr while tx_full SHALL be dropped with FIFO contents unchanged; simultaneous pop and push when full SHALL accept the push.
REQ-025 rx SHALL pass through a 2-flop synchronizer before use.
REQ-026 RX FSM states IDLE, START, DATA, PARITY, STOP; falling edge in IDLE enters START; rx resampled at OVERSAMPLE/2 ticks; if high, return to IDLE (glitch reject).
REQ-027 Data/parity/stop bits sampled at mid-bit (every OVERSAMPLE ticks after start midpoint).
REQ-028 On STOP sample: word pushed to RX FIFO if not full, else discarded and overrun set; stop=0 sets frame_err and the word is still pushed.
REQ-029 rx_rd while rx_empty SHALL be ignored; simultaneous push and pop SHALL keep count constant.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty derived from an extra pointer bit.
REQ-031 err_clr coincident with a new error event SHALL leave the flag set.

Reset
REQ-032 On rst: tx=1, tx_full=0, tx_busy=0, rx_empty=1, read_data=0, all error flags 0, both FSMs IDLE, FIFOs emptied, tick counter 0.
REQ-033 rst mid-frame SHALL abort the frame immediately; tx returns high next cycle; partial RX word discarded.

Configuration
REQ-034 Macro UART2WIFI_UARTX_PARITY_EN: when defined, adds input parity_odd (1 bit), output parity_err (sticky, cleared by err_clr/rst), and a PARITY state in both FSMs; even parity when parity_odd=0.
REQ-035 Without the macro: no PARITY state, no parity_odd/parity_err ports, frame is start+DATA_BITS+stop.

Verification
REQ-036 Defaults, rx driven 0x77 at 52083 ns/bit, twice -> rx_empty falls twice, read_data 0x77 both pops, no errors.
REQ-037 tx_wr 0x86 then 0xFA on consecutive cycles -> tx shows 0,0x86 LSB-first,1 then immediately 0,0xFA,1; tx_busy low after second stop.
REQ-038 rx frame 0x55 with stop bit 0 -> frame_err=1, read_data 0x55; err_clr -> frame_err=0.
REQ-039 17 frames received without rx_rd (FIFO_DEPTH=16) -> overrun=1, 16 pops return first 16 words in order.
REQ-040 rx low pulse of 20 us (< half bit) -> no word, RX FSM back to IDLE.
REQ-041 PARITY_EN defined, parity_odd=0, rx 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err stays 0.
